// File: rtl/sad_search_scheduler_pkg.sv
// Shared constants, types and FSM encoding for the SAD search scheduler.
package sad_pkg;
  localparam int NUM_CORES  = 8;
  localparam int DATA_W     = 32;
  localparam int LANE_W     = DATA_W;               // bits per lane in packed buses
  localparam int LANE_IDX_W = $clog2(NUM_CORES);
  localparam logic [DATA_W-1:0] MIN_INIT = 32'hFFFF_FFFF;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [2*DATA_W-1:0] count_t;             // full-width candidate count
  typedef logic [2*DATA_W:0]   base_t;              // batch base index, one spare bit

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DISPATCH = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_REDUCE   = 3'd3;
  localparam logic [2:0] S_NEXT     = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;
endpackage

// File: rtl/sad_search_scheduler_if.sv
// Scheduler <-> SAD core array bus. The scheduler is the master.
// Handshake: Core_Start pulses for one cycle with Core_Valid/Core_v1/Core_v0
// already valid; those hold until the next Core_Start. Each valid lane raises
// Core_Done (pulse or level) once its Core_MIN is ready, and must hold
// Core_MIN until the next Core_Start.
interface sad_core_if import sad_pkg::*; ();
  logic                        Core_Start;
  logic [NUM_CORES-1:0]        Core_Valid;
  logic [NUM_CORES*DATA_W-1:0] Core_v1;
  logic [NUM_CORES*DATA_W-1:0] Core_v0;
  logic [NUM_CORES-1:0]        Core_Done;
  logic [NUM_CORES*DATA_W-1:0] Core_MIN;

  modport master (output Core_Start, Core_Valid, Core_v1, Core_v0,
                  input  Core_Done, Core_MIN);
  modport slave  (input  Core_Start, Core_Valid, Core_v1, Core_v0,
                  output Core_Done, Core_MIN);
endinterface

// File: rtl/sad_search_scheduler_done_collector.sv
// Per-lane sticky Core_Done latches; all_done once every valid lane reported.
module sad_done_collector import sad_pkg::*; (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 i_clear,
  input  logic [NUM_CORES-1:0] i_valid,
  input  logic [NUM_CORES-1:0] i_done,
  output logic                 o_all_done
);
  logic [NUM_CORES-1:0] r_latch;

  // Accumulate Done pulses; clear on each new batch launch.
  always_ff @(posedge Clk) begin
    if (Rst || i_clear) r_latch <= '0;
    else                r_latch <= r_latch | i_done;
  end

  // Current-cycle Done counts too, so a lane finishing this cycle is seen now.
  assign o_all_done = &(r_latch | i_done | ~i_valid);
endmodule

// File: rtl/sad_search_scheduler.sv
// Full-search SAD scheduler: enumerates the window in batches of NUM_CORES
// candidates, collects per-lane SADs and keeps a running minimum.
module sad_search_scheduler import sad_pkg::*; (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  data_t       V1_Max,
  input  data_t       V0_Max,
  sad_core_if.master  core,
  output logic        Busy,
  output logic        Done,
  output data_t       v1_final,
  output data_t       v0_final,
  output data_t       MIN_final,
  output logic [2:0]  o_dbg_state
);
  logic [2:0]                  r_state;
  data_t                       r_v0_max;
  count_t                      r_n;
  base_t                       r_base;
  data_t                       r_pos_v1, r_pos_v0;
  data_t                       r_min, r_best_v1, r_best_v0;
  logic [LANE_IDX_W-1:0]       r_lane;
  logic [NUM_CORES-1:0]        r_core_valid;
  logic [NUM_CORES*DATA_W-1:0] r_core_v1, r_core_v0;
  logic                        r_busy, r_done;
  data_t                       r_v1_final, r_v0_final, r_min_final;

  count_t                      w_n_in;
  logic [NUM_CORES-1:0]        w_lane_valid;
  logic [NUM_CORES*DATA_W-1:0] w_lane_v1, w_lane_v0;
  data_t                       w_step_v1, w_step_v0;
  data_t                       w_next_v1, w_next_v0;
  logic                        w_all_done;
  logic                        w_dispatch;
  int                          w_lane_off;
  data_t                       w_sel_min, w_sel_v1, w_sel_v0;

  assign w_n_in     = count_t'(V1_Max) * count_t'(V0_Max);
  assign w_dispatch = (r_state == S_DISPATCH);
  assign w_lane_off = int'(r_lane) * LANE_W;
  assign w_sel_min  = core.Core_MIN[w_lane_off +: DATA_W];
  assign w_sel_v1   = r_core_v1[w_lane_off +: DATA_W];
  assign w_sel_v0   = r_core_v0[w_lane_off +: DATA_W];

  sad_done_collector u_done (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_clear    (w_dispatch),
    .i_valid    (r_core_valid),
    .i_done     (core.Core_Done),
    .o_all_done (w_all_done)
  );

  // Walk the window from the batch's first position, v0 innermost.
  always_comb begin
    w_lane_valid = '0;
    w_lane_v1    = '0;
    w_lane_v0    = '0;
    w_step_v1    = r_pos_v1;
    w_step_v0    = r_pos_v0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if ((r_base + base_t'(i)) < {1'b0, r_n}) begin
        w_lane_valid[i]                = 1'b1;
        w_lane_v1[i*LANE_W +: DATA_W]  = w_step_v1;
        w_lane_v0[i*LANE_W +: DATA_W]  = w_step_v0;
      end
      if (w_step_v0 == r_v0_max - data_t'(1)) begin
        w_step_v0 = '0;
        w_step_v1 = w_step_v1 + data_t'(1);
      end else begin
        w_step_v0 = w_step_v0 + data_t'(1);
      end
    end
    w_next_v1 = w_step_v1;
    w_next_v0 = w_step_v0;
  end

  // Search FSM: dispatch, wait, serial reduce, advance, finish.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= S_IDLE;
      r_v0_max     <= '0;
      r_n          <= '0;
      r_base       <= '0;
      r_pos_v1     <= '0;
      r_pos_v0     <= '0;
      r_min        <= '0;
      r_best_v1    <= '0;
      r_best_v0    <= '0;
      r_lane       <= '0;
      r_core_valid <= '0;
      r_core_v1    <= '0;
      r_core_v0    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_v1_final   <= '0;
      r_v0_final   <= '0;
      r_min_final  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_v0_max  <= V0_Max;
            r_n       <= w_n_in;
            r_base    <= '0;
            r_pos_v1  <= '0;
            r_pos_v0  <= '0;
            r_min     <= MIN_INIT;
            r_best_v1 <= '0;
            r_best_v0 <= '0;
            r_busy    <= 1'b1;
            r_state   <= (w_n_in == '0) ? S_FINISH : S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          r_core_valid <= w_lane_valid;
          r_core_v1    <= w_lane_v1;
          r_core_v0    <= w_lane_v0;
          r_pos_v1     <= w_next_v1;
          r_pos_v0     <= w_next_v0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (w_all_done) begin
            r_lane  <= '0;
            r_state <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          // <= so that ties go to the later candidate.
          if (r_core_valid[r_lane] && (w_sel_min <= r_min)) begin
            r_min     <= w_sel_min;
            r_best_v1 <= w_sel_v1;
            r_best_v0 <= w_sel_v0;
          end
          r_lane <= r_lane + LANE_IDX_W'(1);
          if (r_lane == LANE_IDX_W'(NUM_CORES - 1)) r_state <= S_NEXT;
        end
        S_NEXT: begin
          r_base  <= r_base + base_t'(NUM_CORES);
          r_state <= ((r_base + base_t'(NUM_CORES)) < {1'b0, r_n}) ? S_DISPATCH : S_FINISH;
        end
        S_FINISH: begin
          r_v1_final   <= r_best_v1;
          r_v0_final   <= r_best_v0;
          r_min_final  <= r_min;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_core_valid <= '0;
          r_core_v1    <= '0;
          r_core_v0    <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane vectors are live in DISPATCH and held from registers afterwards.
  assign core.Core_Start = w_dispatch;
  assign core.Core_Valid = w_dispatch ? w_lane_valid : r_core_valid;
  assign core.Core_v1    = w_dispatch ? w_lane_v1    : r_core_v1;
  assign core.Core_v0    = w_dispatch ? w_lane_v0    : r_core_v0;

  assign Busy        = r_busy;
  assign Done        = r_done;
  assign v1_final    = r_v1_final;
  assign v0_final    = r_v0_final;
  assign MIN_final   = r_min_final;
  assign o_dbg_state = r_state;
endmodule
